muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer with HI/LO registers, sitting in EX beside the ALU.
//  Accepts one mult/multu/div/divu per start pulse and latches the operands.
//  Holds busy for a fixed latency, then commits the result to HI/LO.
//  mthi/mtlo write HI/LO directly. The hazard unit stalls mfhi/mflo/md ops while busy|start.
// PARAMETERS
//  MUL_LAT  5   cycles busy for mult/multu (legal 1..15)
//  DIV_LAT  10  cycles busy for div/divu (legal 1..15)
// PORTS
//  clk    in   1   clock, rising edge
//  reset  in   1   synchronous, active-high
//  start  in   1   issue md_op this cycle (md ops only; mthi/mtlo need no start)
//  md_op  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored)
//  A      in   32  rs operand (dividend / mthi-mtlo data)
//  B      in   32  rt operand (divisor)
//  busy   out  1   operation in flight
//  hi     out  32  HI register
//  lo     out  32  LO register
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, count=0, busy=0, hi=0, lo=0. Reset mid-operation aborts;
//    the result is never written.
//  FSM IDLE: on edge with start=1 and md_op in 1..4 -> latch A, B, op; count<=LAT-1; busy<=1; go to BUSY.
//    start with md_op 0/5/6/7 does nothing beyond the mthi/mtlo rule below.
//  FSM BUSY: count decrements each edge. On the edge where count==0, write HI/LO, busy<=0, go to IDLE.
//  Latency: start sampled at edge E0; busy=1 for exactly LAT cycles after E0;
//    hi/lo hold the new value from edge E0+LAT onward.
//  Back-to-back issue: start accepted only in IDLE. A start in the cycle busy falls
//    (IDLE at edge) is accepted. Start while BUSY is ignored (the hazard unit guarantees this never happens).
//  mthi (5)/mtlo (6): in IDLE, hi<=A / lo<=A at the next edge; busy stays 0. Ignored while BUSY.
//  Arithmetic, all on latched operands:
//    mult:  {hi,lo} = $signed(A)*$signed(B), 64-bit
//    multu: {hi,lo} = A*B unsigned, 64-bit
//    div:   lo = quotient truncated toward zero; hi = remainder with the sign of the dividend
//    divu:  lo = A/B, hi = A%B unsigned
//    div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0
//  Divide by zero (B==0, div/divu): full latency is still spent with busy high; hi/lo unchanged.
//  Internal operand/op latches are not visible outputs. No combinational path from the inputs to busy/hi/lo.
// TESTING
//  1. multu A=21, B=12 -> busy high 5 cycles; then lo=252, hi=0; busy=0 next cycle.
//  2. mult A=0xFFFFFFFF(-1), B=3 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 5 cycles.
//     multu with same operands -> hi=2, lo=0xFFFFFFFD.
//  3. div A=-7, B=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     divu A=7, B=2 -> lo=3, hi=1.
//  4. mtlo 0x1234 then div A=5, B=0 -> busy 10 cycles; afterwards lo=0x1234 and hi unchanged.
//  5. mult 21*12 issued, then start=1 with div and mthi during busy -> both ignored;
//     final lo=252. New start on the cycle busy drops is accepted.
//  6. multu issued, reset asserted at busy cycle 3 -> next edge busy=0, hi=lo=0;
//     no late write after the original latency.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle mult/div sequencer that owns the HI/LO registers.
// Operands are latched at issue; the result commits to HI/LO when the latency count expires.
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;
   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [63:0] smul, umul;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, res_hi, res_lo;
   logic        sdiv, is_md, commit;
   assign smul   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign umul   = {32'd0, a_q} * {32'd0, b_q};
   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   assign sdiv   = op_q == OP_DIV;
   assign a_mag  = (sdiv && a_q[31]) ? -a_q : a_q;
   assign b_mag  = (sdiv && b_q[31]) ? -b_q : b_q;
   assign q_mag  = a_mag / b_mag;
   assign r_mag  = a_mag % b_mag;
   assign res_hi = op_q == OP_MULT ? smul[63:32] : op_q == OP_MULTU ? umul[63:32] :
                   (sdiv && a_q[31]) ? -r_mag : r_mag;
   assign res_lo = op_q == OP_MULT ? smul[31:0] : op_q == OP_MULTU ? umul[31:0] :
                   (sdiv && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
   assign is_md  = start && md_op >= OP_MULT && md_op <= OP_DIVU;
   assign commit = state_q == BUSY && count_q == 4'd0 &&
                   (op_q == OP_MULT || op_q == OP_MULTU || b_q != 32'd0);
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = commit ? res_hi : hi_q;
      lo_d    = commit ? res_lo : lo_q;
      if (state_q == IDLE) begin
         hi_d = md_op == OP_MTHI ? A : hi_q;
         lo_d = md_op == OP_MTLO ? A : lo_q;
         if (is_md) begin
            state_d = BUSY;
            count_d = md_op <= OP_MULTU ? 4'(MUL_LAT - 1) : 4'(DIV_LAT - 1);
            op_d    = md_op;
            a_d     = A;
            b_d     = B;
         end
      end else begin
         count_d = count_q - 4'd1;
         state_d = count_q == 4'd0 ? IDLE : BUSY;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
   assign busy = state_q == BUSY;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
